// File: rtl/wr_demux_n_pkg.sv
// Shared constants and helpers for the write demultiplexer.
package wr_demux_n_pkg;

   localparam int DROP_CNT_W = 16;

   // Constant-context ceil(log2(value)); clog2(1) is 0.
   function automatic int clog2(input int value);
      int r;
      r = 0;
      for (int i = 0; i < 31; i++) begin
         if ((1 << i) < value) r = i + 1;
      end
      return r;
   endfunction

endpackage

// File: rtl/wr_demux_n.sv
// Routes a valid/ready write stream to NUM_CH channels through one holding register,
// with all-or-nothing broadcast and saturating accounting of out-of-range addresses.
module wr_demux_n
   import wr_demux_n_pkg::*;
#(
   parameter int NUM_CH = 8,
   parameter int DATA_W = 128,
   parameter int ADDR_W = clog2(NUM_CH)
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     in_valid,
   output logic                     in_ready,
   input  logic [ADDR_W-1:0]        in_addr,
   input  logic                     in_bcast,
   input  logic [DATA_W-1:0]        in_data,
   input  logic [NUM_CH-1:0]        ch_full,
   output logic [NUM_CH-1:0]        ch_wr_en,
   output logic [NUM_CH*DATA_W-1:0] ch_din,
   output logic [DROP_CNT_W-1:0]    drop_cnt,
   output logic                     drop_pulse
);

   // Handshake: a word moves when in_valid && in_ready at a rising edge; in_ready
   // never looks at in_valid, and the holding register frees and refills in one edge.
   logic              buf_valid;
   logic [DATA_W-1:0] buf_data;
   logic [NUM_CH-1:0] buf_sel;

   logic              drain;
   logic              accept;
   logic              is_drop;
   logic [NUM_CH-1:0] new_sel;

   always_comb begin
      new_sel = '0;
      is_drop = 1'b0;
      if (in_bcast) begin
         new_sel = '1;
      end else if (int'(in_addr) >= NUM_CH) begin
         is_drop = 1'b1;
      end else begin
         for (int i = 0; i < NUM_CH; i++) begin
            new_sel[i] = (int'(in_addr) == i);
         end
      end
   end

   // A broadcast waits until no selected channel is full, so it never writes a subset.
   assign drain    = buf_valid && ((buf_sel & ch_full) == '0);
   assign in_ready = !buf_valid || drain;
   assign accept   = in_valid && in_ready;
   assign ch_wr_en = buf_sel & {NUM_CH{drain}};

   for (genvar g = 0; g < NUM_CH; g++) begin : g_din
      assign ch_din[g*DATA_W +: DATA_W] = (buf_valid && buf_sel[g]) ? buf_data : '0;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         buf_valid  <= 1'b0;
         buf_data   <= '0;
         buf_sel    <= '0;
         drop_cnt   <= '0;
         drop_pulse <= 1'b0;
      end else begin
         drop_pulse <= accept && is_drop;
         if (accept && is_drop && (drop_cnt != '1)) begin
            drop_cnt <= drop_cnt + DROP_CNT_W'(1);
         end
         if (accept && !is_drop) begin
            buf_valid <= 1'b1;
            buf_data  <= in_data;
            buf_sel   <= new_sel;
         end else if (drain) begin
            buf_valid <= 1'b0;
            buf_data  <= '0;
            buf_sel   <= '0;
         end
      end
   end

endmodule

// File: tb/tb_wr_demux_n.sv
// Bench for wr_demux_n: three parameterisations, directed vectors plus a randomized
// 4-channel stream, with per-instance expected queues drained by negedge monitors.
module tb_wr_demux_n;

   logic clk;
   logic rst_n;

   // 8 channels x 128 bits
   logic         in_valid8, in_ready8, in_bcast8, drop_pulse8;
   logic [2:0]   in_addr8;
   logic [127:0] in_data8;
   logic [7:0]   ch_full8, ch_wr_en8;
   logic [1023:0] ch_din8;
   logic [15:0]  drop_cnt8;

   // 6 channels x 16 bits
   logic         in_valid6, in_ready6, in_bcast6, drop_pulse6;
   logic [2:0]   in_addr6;
   logic [15:0]  in_data6;
   logic [5:0]   ch_full6, ch_wr_en6;
   logic [95:0]  ch_din6;
   logic [15:0]  drop_cnt6;

   // 4 channels x 32 bits
   logic         in_valid4, in_ready4, in_bcast4, drop_pulse4;
   logic [1:0]   in_addr4;
   logic [31:0]  in_data4;
   logic [3:0]   ch_full4, ch_wr_en4;
   logic [127:0] ch_din4;
   logic [15:0]  drop_cnt4;

   // Expected writes: {channel mask, data}
   logic [135:0] exp8_q[$];
   logic [21:0]  exp6_q[$];
   logic [35:0]  exp4_q[$];

   int n_checks = 0;
   int n_errors = 0;

   wr_demux_n #(.NUM_CH(8), .DATA_W(128), .ADDR_W(3)) dut8 (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid8), .in_ready(in_ready8),
      .in_addr(in_addr8), .in_bcast(in_bcast8), .in_data(in_data8),
      .ch_full(ch_full8), .ch_wr_en(ch_wr_en8), .ch_din(ch_din8),
      .drop_cnt(drop_cnt8), .drop_pulse(drop_pulse8));

   wr_demux_n #(.NUM_CH(6), .DATA_W(16), .ADDR_W(3)) dut6 (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid6), .in_ready(in_ready6),
      .in_addr(in_addr6), .in_bcast(in_bcast6), .in_data(in_data6),
      .ch_full(ch_full6), .ch_wr_en(ch_wr_en6), .ch_din(ch_din6),
      .drop_cnt(drop_cnt6), .drop_pulse(drop_pulse6));

   wr_demux_n #(.NUM_CH(4), .DATA_W(32), .ADDR_W(2)) dut4 (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid4), .in_ready(in_ready4),
      .in_addr(in_addr4), .in_bcast(in_bcast4), .in_data(in_data4),
      .ch_full(ch_full4), .ch_wr_en(ch_wr_en4), .ch_din(ch_din4),
      .drop_cnt(drop_cnt4), .drop_pulse(drop_pulse4));

   // ---------------- clock / reset ----------------
   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #1_500_000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

   task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   // ---------------- scoreboard monitors ----------------
   logic [135:0] m8;
   logic [21:0]  m6;
   logic [35:0]  m4;

   always @(negedge clk) begin
      if (rst_n && ch_wr_en8 != '0) begin
         if (exp8_q.size() == 0) begin
            check("dut8_unexpected_write", 256'(ch_wr_en8), 256'(0));
         end else begin
            m8 = exp8_q.pop_front();
            check("dut8_wr_en", 256'(ch_wr_en8), 256'(m8[135:128]));
            for (int i = 0; i < 8; i++)
               if (m8[128+i]) check("dut8_din", 256'(ch_din8[i*128 +: 128]), 256'(m8[127:0]));
         end
      end
   end

   always @(negedge clk) begin
      if (rst_n && ch_wr_en6 != '0) begin
         if (exp6_q.size() == 0) begin
            check("dut6_unexpected_write", 256'(ch_wr_en6), 256'(0));
         end else begin
            m6 = exp6_q.pop_front();
            check("dut6_wr_en", 256'(ch_wr_en6), 256'(m6[21:16]));
            for (int i = 0; i < 6; i++)
               if (m6[16+i]) check("dut6_din", 256'(ch_din6[i*16 +: 16]), 256'(m6[15:0]));
         end
      end
   end

   always @(negedge clk) begin
      if (rst_n && ch_wr_en4 != '0) begin
         if (exp4_q.size() == 0) begin
            check("dut4_unexpected_write", 256'(ch_wr_en4), 256'(0));
         end else begin
            m4 = exp4_q.pop_front();
            check("dut4_wr_en", 256'(ch_wr_en4), 256'(m4[35:32]));
            for (int i = 0; i < 4; i++)
               if (m4[32+i]) check("dut4_din", 256'(ch_din4[i*32 +: 32]), 256'(m4[31:0]));
         end
      end
   end

   // ---------------- stimulus ----------------
   logic acc4;

   initial begin
      rst_n = 1'b0;
      in_valid8 = 0; in_addr8 = '0; in_bcast8 = 0; in_data8 = '0; ch_full8 = '0;
      in_valid6 = 0; in_addr6 = '0; in_bcast6 = 0; in_data6 = '0; ch_full6 = '0;
      in_valid4 = 0; in_addr4 = '0; in_bcast4 = 0; in_data4 = '0; ch_full4 = '0;
      acc4 = 1'b0;

      // reset state
      #2;
      check("rst_ready8", 256'(in_ready8), 256'(1));
      check("rst_wr_en8", 256'(ch_wr_en8), 256'(0));
      check("rst_din8", 256'(ch_din8 != '0), 256'(0));
      check("rst_drop_cnt6", 256'(drop_cnt6), 256'(0));
      check("rst_drop_pulse6", 256'(drop_pulse6), 256'(0));
      check("rst_ready4", 256'(in_ready4), 256'(1));
      next_cycle();
      next_cycle();
      rst_n = 1'b1;
      next_cycle();

      // unicast 0..7 back to back, data = addr
      for (int k = 0; k < 8; k++) begin
         in_valid8 = 1'b1; in_bcast8 = 1'b0; in_addr8 = 3'(k); in_data8 = 128'(k);
         exp8_q.push_back({8'(1 << k), 128'(k)});
         @(negedge clk);
         check("uni_ready", 256'(in_ready8), 256'(1));
         if (k > 0) check("uni_latency", 256'(ch_wr_en8), 256'(1 << (k - 1)));
         next_cycle();
      end
      in_valid8 = 1'b0;
      @(negedge clk);
      check("uni_last", 256'(ch_wr_en8), 256'(8'h80));
      next_cycle();
      @(negedge clk);
      check("uni_idle", 256'(ch_wr_en8), 256'(0));
      next_cycle();

      // stall on channel 3, with a second word for channel 5 waiting behind it
      ch_full8 = 8'h08;
      in_valid8 = 1'b1; in_addr8 = 3'd3; in_data8 = 128'hDEAD_0003;
      exp8_q.push_back({8'h08, 128'hDEAD_0003});
      @(negedge clk);
      check("stall_accept_ready", 256'(in_ready8), 256'(1));
      next_cycle();
      in_addr8 = 3'd5; in_data8 = 128'hBEEF_0005;
      exp8_q.push_back({8'h20, 128'hBEEF_0005});
      for (int c = 0; c < 5; c++) begin
         @(negedge clk);
         check("stall_wr_en", 256'(ch_wr_en8), 256'(0));
         check("stall_ready", 256'(in_ready8), 256'(0));
         next_cycle();
      end
      ch_full8 = 8'h00;
      @(negedge clk);
      check("stall_release_wr_en", 256'(ch_wr_en8), 256'(8'h08));
      check("stall_release_ready", 256'(in_ready8), 256'(1));
      next_cycle();
      in_valid8 = 1'b0;
      @(negedge clk);
      check("stall_follow_wr_en", 256'(ch_wr_en8), 256'(8'h20));
      next_cycle();
      @(negedge clk);
      check("stall_idle", 256'(ch_wr_en8), 256'(0));
      next_cycle();

      // broadcast blocked by channel 6 for 3 cycles
      ch_full8 = 8'h40;
      in_valid8 = 1'b1; in_bcast8 = 1'b1; in_addr8 = 3'd3; in_data8 = 128'hA5;
      exp8_q.push_back({8'hFF, 128'hA5});
      next_cycle();
      in_valid8 = 1'b0; in_bcast8 = 1'b0;
      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         check("bcast_blocked", 256'(ch_wr_en8), 256'(0));
         next_cycle();
      end
      ch_full8 = 8'h00;
      @(negedge clk);
      check("bcast_release", 256'(ch_wr_en8), 256'(8'hFF));
      next_cycle();
      @(negedge clk);
      check("bcast_once", 256'(ch_wr_en8), 256'(0));
      next_cycle();

      // drops on the 6-channel instance
      in_valid6 = 1'b1; in_addr6 = 3'd7; in_data6 = 16'h7777;
      @(negedge clk);
      check("drop_ready", 256'(in_ready6), 256'(1));
      check("drop_cnt_before", 256'(drop_cnt6), 256'(0));
      next_cycle();
      in_valid6 = 1'b0;
      @(negedge clk);
      check("drop_pulse", 256'(drop_pulse6), 256'(1));
      check("drop_cnt_one", 256'(drop_cnt6), 256'(1));
      check("drop_no_write", 256'(ch_wr_en6), 256'(0));
      next_cycle();
      @(negedge clk);
      check("drop_pulse_once", 256'(drop_pulse6), 256'(0));
      in_valid6 = 1'b1; in_addr6 = 3'd5; in_data6 = 16'h5555;
      exp6_q.push_back({6'h20, 16'h5555});
      next_cycle();
      in_addr6 = 3'd6; in_data6 = 16'h6666;
      @(negedge clk);
      check("top_chan_write", 256'(ch_wr_en6), 256'(6'h20));
      next_cycle();
      in_valid6 = 1'b0;
      @(negedge clk);
      check("drop_addr6_pulse", 256'(drop_pulse6), 256'(1));
      check("drop_addr6_cnt", 256'(drop_cnt6), 256'(2));
      check("drop_addr6_no_write", 256'(ch_wr_en6), 256'(0));
      next_cycle();
      in_valid6 = 1'b1; in_addr6 = 3'd7;
      repeat (65538) next_cycle();
      in_valid6 = 1'b0;
      @(negedge clk);
      check("drop_cnt_saturated", 256'(drop_cnt6), 256'(16'hFFFF));
      check("drop_pulse_at_sat", 256'(drop_pulse6), 256'(1));
      next_cycle();
      @(negedge clk);
      check("drop_cnt_held", 256'(drop_cnt6), 256'(16'hFFFF));
      next_cycle();

      // reset while a word is stalled: it must vanish without a write
      ch_full8 = 8'h10;
      in_valid8 = 1'b1; in_addr8 = 3'd4; in_data8 = 128'h1234;
      next_cycle();
      in_valid8 = 1'b0;
      @(negedge clk);
      check("rst_stall_ready", 256'(in_ready8), 256'(0));
      check("rst_stall_din", 256'(ch_din8[4*128 +: 128]), 256'(128'h1234));
      #2;
      rst_n = 1'b0;
      #1;
      check("rst_async_ready", 256'(in_ready8), 256'(1));
      check("rst_async_din", 256'(ch_din8 != '0), 256'(0));
      check("rst_async_wr_en", 256'(ch_wr_en8), 256'(0));
      check("rst_async_drop_cnt", 256'(drop_cnt6), 256'(0));
      next_cycle();
      ch_full8 = 8'h00;
      next_cycle();
      rst_n = 1'b1;
      for (int c = 0; c < 4; c++) begin
         @(negedge clk);
         check("rst_no_write", 256'(ch_wr_en8), 256'(0));
         next_cycle();
      end

      // randomized 4-channel stream; source holds a word until it is taken
      for (int c = 0; c < 400; c++) begin
         if (!in_valid4 || acc4) begin
            if ($urandom_range(0, 9) < 7) begin
               in_valid4 = 1'b1;
               in_bcast4 = ($urandom_range(0, 7) == 0);
               in_addr4  = 2'($urandom_range(0, 3));
               in_data4  = $urandom;
            end else begin
               in_valid4 = 1'b0;
            end
         end
         ch_full4 = 4'($urandom_range(0, 15)) & 4'($urandom_range(0, 15));
         @(negedge clk);
         acc4 = in_valid4 && in_ready4;
         if (acc4) exp4_q.push_back({in_bcast4 ? 4'hF : 4'(1 << in_addr4), in_data4});
         next_cycle();
      end
      in_valid4 = 1'b0;
      ch_full4 = 4'h0;
      for (int c = 0; c < 10 && exp4_q.size() != 0; c++) next_cycle();
      next_cycle();

      check("dut4_queue_empty", 256'(exp4_q.size()), 256'(0));
      check("dut8_queue_empty", 256'(exp8_q.size()), 256'(0));
      check("dut6_queue_empty", 256'(exp6_q.size()), 256'(0));

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule

// File: doc/wr_demux_n.md
WR_DEMUX_N -- requirements
Module: wr_demux_n

Interface
REQ-001 SHALL have parameter NUM_CH, default 8, meaning the number of output channels (2..16).
REQ-002 SHALL have parameter DATA_W, default 128, meaning the word width.
REQ-003 SHALL have parameter ADDR_W, default 3, meaning the address width, with ADDR_W = clog2(NUM_CH).
REQ-004 SHALL have the port: clk  input  1  sole clock, rising edge.
REQ-005 SHALL have the port: rst_n  input  1  reset, asynchronous, active-low.
REQ-006 SHALL have the port: in_valid  input  1  upstream word valid.
REQ-007 SHALL have the port: in_ready  output  1  block accepts the word this cycle.
REQ-008 SHALL have the port: in_addr  input  ADDR_W  target channel.
REQ-009 SHALL have the port: in_bcast  input  1  write to all channels; in_addr is ignored.
REQ-010 SHALL have the port: in_data  input  DATA_W  write word.
REQ-011 SHALL have the port: ch_full  input  NUM_CH  per-channel full flag; bit i is channel i.
REQ-012 SHALL have the port: ch_wr_en  output  NUM_CH  per-channel one-cycle write strobe.
REQ-013 SHALL have the port: ch_din  output  NUM_CH*DATA_W  per-channel data; slice i is bits [i*DATA_W +: DATA_W].
REQ-014 SHALL have the port: drop_cnt  output  16  count of dropped words, saturating.
REQ-015 SHALL have the port: drop_pulse  output  1  one-cycle pulse for each dropped word.

Function
REQ-016 SHALL transfer a word when in_valid && in_ready are both high at a rising clk edge.
REQ-017 SHALL hold each accepted word in a single-entry holding register consisting of buf_valid, buf_data, buf_sel[NUM_CH].
REQ-018 SHALL set buf_sel to one-hot(in_addr) for a unicast word.
REQ-019 SHALL set buf_sel to all-ones for a word with in_bcast=1.
REQ-020 SHALL treat a unicast word with in_addr >= NUM_CH as a drop: accept it without buffering, pulse drop_pulse in the next cycle, and increment drop_cnt, saturating at 16'hFFFF.
REQ-021 SHALL compute drain = buf_valid && ((buf_sel & ch_full) == 0) combinationally.
REQ-022 SHALL make a broadcast word all-or-nothing: it drains only when every channel is not full, and it never writes a partial subset of channels.
REQ-023 SHALL drive ch_wr_en[i] = drain && buf_sel[i], with no added register stage.
REQ-024 SHALL drive ch_din slice i = buf_data when buf_sel[i] && buf_valid, and zero otherwise.
REQ-025 SHALL drive in_ready = !buf_valid || drain, so that a full-rate stream passes at 1 word/cycle with no bubble.
REQ-026 SHALL give a latency of exactly 1 cycle from acceptance to the earliest ch_wr_en.
REQ-027 SHALL NOT let a stalled word affect any other channel: ch_wr_en stays 0 for all channels until the drain occurs.
REQ-028 SHALL, on a simultaneous drain and accept, load the new word into the holding register in the same cycle.
REQ-029 SHALL only sample ch_full; ch_full changing while a word is held only affects the drain timing.
REQ-030 SHALL ignore in_addr, in_bcast and in_data whenever in_valid=0.

Reset
REQ-031 SHALL, while rst_n=0, asynchronously clear buf_valid, buf_sel, buf_data, drop_cnt and drop_pulse, which gives ch_wr_en=0, ch_din=0 and in_ready=1.
REQ-032 SHALL discard a word held in the holding register when reset is asserted mid-stall, with no write issued.
REQ-033 SHALL release reset synchronously to clk, so that the first acceptance occurs no earlier than the first edge with rst_n=1.

Structure
REQ-034 SHALL place the drop-counter width constant (16) and a clog2 helper function in the shared ftl package.
REQ-035 SHALL be implemented as a single module with no sub-modules; the holding register is inline.
REQ-036 SHALL contain no combinational path from in_valid to ch_wr_en.

Verification
REQ-037 SHALL verify unicast: NUM_CH=8, all ch_full=0, send addr 0..7 back-to-back with data=addr -> ch_wr_en[k] in cycles 1..8, ch_din[k]=k, in_ready held at 1.
REQ-038 SHALL verify a stall: send addr 3 with ch_full[3]=1 for 5 cycles -> ch_wr_en=0 and in_ready=0 for 5 cycles; the write occurs in the cycle ch_full[3] falls; other channels remain silent.
REQ-039 SHALL verify broadcast: in_bcast=1, data=A5, ch_full[6]=1 for 3 cycles -> no strobe for 3 cycles, then ch_wr_en=8'hFF exactly once with every slice = A5.
REQ-040 SHALL verify a drop: NUM_CH=6, addr 7 -> accepted, drop_pulse one cycle, drop_cnt 0->1, ch_wr_en=0; 65540 drops -> drop_cnt=FFFF.
REQ-041 SHALL verify reset mid-stall: hold a word with ch_full=1, assert rst_n=0 -> in_ready=1 and ch_din=0 immediately; after release, no write is issued.
REQ-042 SHALL verify parameters: NUM_CH=4, DATA_W=32, random stimulus against a scoreboard -> per-channel order preserved and no lost or duplicate words.
